// File: rtl/v_word_serializer_pkg.sv
// -----------------------------------------------------------------------------
// v_word_serializer_pkg
//   Shared definitions for the word serializer and its strobe prescaler:
//   FSM state encoding and a counter-width helper.
// -----------------------------------------------------------------------------
package v_word_serializer_pkg;

  // Serializer FSM states.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Bits needed to count 0..n-1. Never returns less than 1, so that a
  // count of 1 still gets a legal one-bit vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/v_strobe_prescaler.sv
// -----------------------------------------------------------------------------
// v_strobe_prescaler
//   Free-running divide-by-DIV counter that produces a one-cycle strobe on
//   the last count of every period while running.
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   run      in   count while high; the counter is held at 0 while low
//   restart  in   force the counter back to 0 at the next edge
//   strobe   out  run & (count == DIV-1)
// -----------------------------------------------------------------------------
module v_strobe_prescaler
  import v_word_serializer_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic strobe
);

  localparam int             CW   = cnt_width(DIV);
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (restart || !run) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // With DIV=1 the counter is stuck at 0 and the strobe follows run.
  assign strobe = run && (r_cnt == LAST);

endmodule

// File: rtl/v_word_serializer.sv
// -----------------------------------------------------------------------------
// v_word_serializer
//   Parallel-to-serial front end. Accepts WIDTH-bit words on a valid/ready
//   handshake, buffers one extra word, and emits one bit per DIV clocks on
//   so with a one-cycle so_en strobe. A buffered word is loaded on the edge
//   that consumes the last bit of the current word, so back-to-back words
//   stream with an unbroken strobe period.
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   din        in   parallel word, sampled only at the accept edge
//   din_valid  in   din is valid
//   din_ready  out  hold register empty (flop-only, no path from din_valid)
//   so         out  serial bit (0 outside SHIFT)
//   so_en      out  one-cycle bit strobe
//   busy       out  shifting or hold register full
//   word_done  out  one-cycle pulse the cycle after a word's last strobe
// -----------------------------------------------------------------------------
module v_word_serializer
  import v_word_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_en,
  output logic             busy,
  output logic             word_done
);

  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [BW-1:0]    r_bitcnt;
  logic             r_word_done;

  logic w_strobe;
  logic w_accept;
  logic w_last;
  logic w_load_din;
  logic w_load_hold;
  logic w_hold_wr;

  assign din_ready = !r_hold_full;
  assign w_accept  = din_valid && din_ready;
  assign w_last    = w_strobe && (r_bitcnt == BIT_LAST);

  v_strobe_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .run    (r_state == S_SHIFT),
    .restart(w_load_din || w_load_hold),
    .strobe (w_strobe)
  );

  // Next-state and load decode.
  // NOTE: every output of this block gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load_din  = 1'b0;
    w_load_hold = 1'b0;
    w_hold_wr   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Hold is always empty here, so the word bypasses it.
        if (w_accept) begin
          w_load_din  = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          if (r_hold_full) begin
            w_load_hold = 1'b1;
          end else if (w_accept) begin
            w_load_din  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_accept) begin
          w_hold_wr = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shift register and bit counter. Shifting moves bits toward the output
  // end with zero fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg  <= '0;
      r_bitcnt <= '0;
    end else if (w_load_din) begin
      r_shreg  <= din;
      r_bitcnt <= '0;
    end else if (w_load_hold) begin
      r_shreg  <= r_hold;
      r_bitcnt <= '0;
    end else if (w_strobe) begin
      if (MSB_FIRST != 0) begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      end else begin
        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      end
      r_bitcnt <= r_bitcnt + BW'(1);
    end
  end

  // One-word holding buffer.
  // NOTE: the hold data is reset along with its full flag even though the
  // flag alone qualifies it; a single register costs nothing to clear and it
  // keeps reset state fully deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_load_hold) begin
      r_hold_full <= 1'b0;
    end else if (w_hold_wr) begin
      r_hold      <= din;
      r_hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= w_last;
    end
  end

  assign so_en     = w_strobe;
  assign so        = (r_state == S_SHIFT) &&
                     ((MSB_FIRST != 0) ? r_shreg[WIDTH-1] : r_shreg[0]);
  assign busy      = (r_state == S_SHIFT) || r_hold_full;
  assign word_done = r_word_done;

endmodule

// File: tb/tb_v_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_v_word_serializer
//   Directed bench. dut0: WIDTH=8, DIV=4, MSB first, feeding a modelled 8-bit
//   shift register. dut1: WIDTH=8, DIV=1, LSB first. Cycle k means the k-th
//   clock period after the accept edge.
// -----------------------------------------------------------------------------
module tb_v_word_serializer;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] din0, din1;
  logic       valid0, valid1;
  logic       ready0, ready1;
  logic       so0, so1;
  logic       so_en0, so_en1;
  logic       busy0, busy1;
  logic       done0, done1;

  logic [7:0] sr0 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  v_word_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1)) dut0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(valid0), .din_ready(ready0),
    .so(so0), .so_en(so_en0), .busy(busy0), .word_done(done0)
  );

  v_word_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(0)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(valid1), .din_ready(ready1),
    .so(so1), .so_en(so_en1), .busy(busy1), .word_done(done1)
  );

  // Downstream 8-bit shift register: SI=so, clken=so_en, shifting toward MSB.
  always @(posedge clk) begin
    if (so_en0) sr0 <= {sr0[6:0], so0};
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one word into idle dut0 and check the full bit stream.
  task automatic run_word0(input logic [7:0] w);
    logic [7:0] wv;
    logic       exp_en;
    int         n;
    wv = w;
    din0 = w; valid0 = 1'b1;
    check("w0_ready_before", ready0, 1'b1);
    tick();                              // accept edge
    valid0 = 1'b0; din0 = ~w;            // later din changes must not matter
    for (int k = 1; k <= 34; k++) begin
      exp_en = (k % 4 == 0) && (k <= 32);
      check($sformatf("w%02h_so_en_c%0d", w, k), so_en0, exp_en);
      if (exp_en) begin
        n = k / 4;
        check($sformatf("w%02h_so_bit%0d", w, n), so0, wv[8-n]);
      end
      check($sformatf("w%02h_done_c%0d", w, k), done0, (k == 33));
      check($sformatf("w%02h_busy_c%0d", w, k), busy0, (k <= 32));
      if (k == 33) check($sformatf("w%02h_chain", w), sr0, w);
      tick();
    end
    check($sformatf("w%02h_so_idle", w), so0, 1'b0);
  endtask

  initial begin
    logic [7:0] w3a, w3b, w2;
    logic       exp_en;
    int         n, cnt_en, cnt_done, any_busy, any_so;

    rst = 1'b1;
    din0 = 8'hFF; valid0 = 1'b1;       // must not be accepted during reset
    din1 = 8'hFF; valid1 = 1'b1;
    #2;
    check("rst_ready", ready0, 1'b1);
    check("rst_so", so0, 1'b0);
    check("rst_so_en", so_en0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    tick(); tick();
    check("rst_busy_held", busy0, 1'b0);
    valid0 = 1'b0; valid1 = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_idle_busy", busy0, 1'b0);
    check("post_rst_idle_busy1", busy1, 1'b0);

    // 1) 0xA5 MSB first, DIV=4; also checks the downstream register.
    run_word0(8'hA5);

    // 2) dut1: 0x01 LSB first, DIV=1 -> 1,0,0,0,0,0,0,0 on 8 consecutive cycles.
    w2 = 8'h01;
    din1 = w2; valid1 = 1'b1;
    tick();
    valid1 = 1'b0; din1 = 8'hFE;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("d1_so_en_c%0d", k), so_en1, (k <= 8));
      if (k <= 8) check($sformatf("d1_so_bit%0d", k), so1, w2[k-1]);
      check($sformatf("d1_done_c%0d", k), done1, (k == 9));
      tick();
    end
    check("d1_busy_end", busy1, 1'b0);

    // 3) 0x3C then 0xC3 back to back through the hold register.
    w3a = 8'h3C; w3b = 8'hC3;
    din0 = w3a; valid0 = 1'b1;
    tick();                              // E0: 0x3C into shreg
    check("b2b_ready_c1", ready0, 1'b1);
    din0 = w3b;
    tick();                              // E1: 0xC3 into hold
    valid0 = 1'b0; din0 = 8'h00;
    for (int k = 2; k <= 68; k++) begin
      exp_en = (k % 4 == 0) && (k <= 64);
      check($sformatf("b2b_so_en_c%0d", k), so_en0, exp_en);
      if (exp_en) begin
        n = k / 4;
        if (n <= 8) check($sformatf("b2b_so_a_bit%0d", n), so0, w3a[8-n]);
        else        check($sformatf("b2b_so_b_bit%0d", n), so0, w3b[16-n]);
      end
      check($sformatf("b2b_done_c%0d", k), done0, (k == 33) || (k == 65));
      check($sformatf("b2b_ready_c%0d", k), ready0, (k >= 33));
      check($sformatf("b2b_busy_c%0d", k), busy0, (k <= 64));
      if (k == 65) check("b2b_chain", sr0, w3b);
      tick();
    end

    // 4) Reset mid-word with a word waiting in hold.
    din0 = 8'hFF; valid0 = 1'b1;
    tick();                              // E0
    din0 = 8'h77;
    tick();                              // E1: 0x77 into hold
    valid0 = 1'b0;
    for (int k = 2; k < 12; k++) tick();
    check("mid_3rd_strobe", so_en0, 1'b1);
    check("mid_so_before", so0, 1'b1);
    tick();                              // cycle 13
    check("mid_busy_before", busy0, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_so", so0, 1'b0);
    check("mid_rst_so_en", so_en0, 1'b0);
    check("mid_rst_busy", busy0, 1'b0);
    check("mid_rst_ready", ready0, 1'b1);
    check("mid_rst_done", done0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    cnt_en = 0; cnt_done = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (so_en0) cnt_en++;
      if (done0) cnt_done++;
    end
    check("mid_no_strobes_after", cnt_en, 0);
    check("mid_no_word_done", cnt_done, 0);
    run_word0(8'h5A);

    // 5) Chain with downstream shift register.
    run_word0(8'h96);

    // 6) din_valid low for 100 cycles.
    cnt_en = 0; any_busy = 0; any_so = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (so_en0) cnt_en++;
      if (busy0) any_busy++;
      if (so0) any_so++;
    end
    check("idle_so_en", cnt_en, 0);
    check("idle_busy", any_busy, 0);
    check("idle_so", any_so, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
